// File: rtl/regs_system_ahbl_if.sv
// AHB-Lite bus bundle for the system configuration register slot.
// The master modport is the fabric side; HREADY is the fabric's combined ready.
`timescale 1ns/1ps
interface regs_system_ahbl_if #(
    parameter int ADDR_W = 8
) ();
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [31:0]       HWDATA;
    logic              HREADY;
    logic              HREADYOUT;
    logic              HRESP;
    logic [31:0]       HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/regs_system_ahbl.sv
// AHB-Lite subordinate holding the system configuration registers (muxsplit, vref, user, sio, status).
// Define MUXSPLIT_BBM_EN to add a per-quadrant break-before-make interval on the muxsplit outputs.
`timescale 1ns/1ps
module regs_system_ahbl #(
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int BBM_CYCLES  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    regs_system_ahbl_if.slave ahb,

    output logic              bus_muxsplit_se_switch_aa_sl,
    output logic              bus_muxsplit_se_switch_aa_s0,
    output logic              bus_muxsplit_se_switch_bb_s0,
    output logic              bus_muxsplit_se_switch_bb_sl,
    output logic              bus_muxsplit_se_switch_bb_sr,
    output logic              bus_muxsplit_se_switch_aa_sr,
    output logic              bus_muxsplit_sw_switch_aa_sl,
    output logic              bus_muxsplit_sw_switch_aa_s0,
    output logic              bus_muxsplit_sw_switch_bb_s0,
    output logic              bus_muxsplit_sw_switch_bb_sl,
    output logic              bus_muxsplit_sw_switch_bb_sr,
    output logic              bus_muxsplit_sw_switch_aa_sr,
    output logic              bus_muxsplit_ne_switch_aa_sl,
    output logic              bus_muxsplit_ne_switch_aa_s0,
    output logic              bus_muxsplit_ne_switch_bb_s0,
    output logic              bus_muxsplit_ne_switch_bb_sl,
    output logic              bus_muxsplit_ne_switch_bb_sr,
    output logic              bus_muxsplit_ne_switch_aa_sr,
    output logic              bus_muxsplit_nw_switch_aa_sl,
    output logic              bus_muxsplit_nw_switch_aa_s0,
    output logic              bus_muxsplit_nw_switch_bb_s0,
    output logic              bus_muxsplit_nw_switch_bb_sl,
    output logic              bus_muxsplit_nw_switch_bb_sr,
    output logic              bus_muxsplit_nw_switch_aa_sr,

    output logic              bus_vref_e_vrefgen_en,
    output logic              bus_vref_w_vrefgen_en,
    output logic [4:0]        bus_vref_e_ref_sel,
    output logic [4:0]        bus_vref_w_ref_sel,
    output logic              bus_user_ahb_enable,
    output logic [15:0]       bus_user_irqs_enable,
    output logic [5:0]        bus_sio_cfg,

    input  logic              bus_mgmt_select,
    output logic [1:0]        dbg_state
);

    if (SYNC_STAGES < 2 || BBM_CYCLES < 1) begin : g_param_check
        $error("regs_system_ahbl: SYNC_STAGES must be >= 2 and BBM_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        ST_OKAY = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_e;

    state_e                 state_q;
    logic                   hreadyout_q;
    logic                   hresp_q;

    logic                   dp_valid_q, dp_valid_d;
    logic                   dp_write_q, dp_write_d;
    logic [2:0]             dp_idx_q, dp_idx_d;
    logic [3:0]             dp_lanes_q, dp_lanes_d;
    logic [31:0]            hrdata_q, hrdata_d;
    logic [31:0]            regs_q [7];
    logic [31:0]            regs_d [7];
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    logic                   take;
    logic                   bad;
    logic [3:0]             lanes;
    logic [2:0]             a_idx;
    logic [31:0]            wmask;
    logic [31:0]            rd_val;
    logic [5:0]             mux_out [4];
    logic                   unused_htrans0;

    // Storage keeps only implemented bits so readback of the rest is zero.
    function automatic logic [31:0] impl_mask(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2, 3'd3: impl_mask = 32'h0000_003F;
            3'd4:                   impl_mask = 32'h011F_011F;
            3'd5:                   impl_mask = 32'hFFFF_0001;
            3'd6:                   impl_mask = 32'h0000_003F;
            default:                impl_mask = 32'h0000_0000;
        endcase
    endfunction

    assign unused_htrans0 = ahb.HTRANS[0];

    // Handshake: an address phase is taken when HSEL & HREADY & HTRANS[1] at a clock edge;
    // its data phase completes at the next edge on which HREADYOUT is high.
    always_comb begin
        take = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1] & (state_q != ST_ERR1);
        a_idx = ahb.HADDR[4:2];
        case (ahb.HSIZE)
            3'd0:    lanes = 4'b0001 << ahb.HADDR[1:0];
            3'd1:    lanes = ahb.HADDR[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
        bad = (ahb.HADDR >= ADDR_W'(32)) | (ahb.HSIZE > 3'd2)
            | ((ahb.HSIZE == 3'd1) & ahb.HADDR[0])
            | ((ahb.HSIZE == 3'd2) & (ahb.HADDR[1:0] != 2'b00));

        wmask = {{8{dp_lanes_q[3]}}, {8{dp_lanes_q[2]}}, {8{dp_lanes_q[1]}}, {8{dp_lanes_q[0]}}};
        for (int i = 0; i < 7; i++) begin
            regs_d[i] = regs_q[i];
            if (dp_valid_q && dp_write_q && (dp_idx_q == 3'(i))) begin
                regs_d[i] = ((regs_q[i] & ~wmask) | (ahb.HWDATA & wmask)) & impl_mask(3'(i));
            end
        end

        // Reading from the next-state values gives read-after-write bypass for free.
        rd_val = {31'd0, sync_q[SYNC_STAGES-1]};
        for (int i = 0; i < 7; i++) begin
            if (a_idx == 3'(i)) begin
                rd_val = regs_d[i];
            end
        end

        dp_valid_d = take & ~bad;
        dp_write_d = ahb.HWRITE;
        dp_idx_d   = a_idx;
        dp_lanes_d = lanes;
        hrdata_d   = (take & ~bad & ~ahb.HWRITE) ? rd_val : 32'd0;
        sync_d     = {sync_q[SYNC_STAGES-2:0], bus_mgmt_select};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_OKAY;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_ERR1: begin
                    state_q     <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b1;
                end
                default: begin
                    if (take && bad) begin
                        state_q     <= ST_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= 1'b1;
                    end else begin
                        state_q     <= ST_OKAY;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_idx_q   <= 3'd0;
            dp_lanes_q <= 4'd0;
            hrdata_q   <= 32'd0;
            sync_q     <= '0;
            for (int i = 0; i < 7; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_idx_q   <= dp_idx_d;
            dp_lanes_q <= dp_lanes_d;
            hrdata_q   <= hrdata_d;
            sync_q     <= sync_d;
            for (int i = 0; i < 7; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

`ifdef MUXSPLIT_BBM_EN
    localparam int CNT_W = $clog2(BBM_CYCLES + 1);

    logic [CNT_W-1:0] bbm_cnt_q [4];
    logic [CNT_W-1:0] bbm_cnt_d [4];

    // A changing commit reloads the quadrant's break; the output is held low while it runs.
    always_comb begin
        for (int q = 0; q < 4; q++) begin
            bbm_cnt_d[q] = (bbm_cnt_q[q] != '0) ? bbm_cnt_q[q] - 1'b1 : '0;
            if (regs_d[q] != regs_q[q]) begin
                bbm_cnt_d[q] = CNT_W'(BBM_CYCLES);
            end
            mux_out[q] = (bbm_cnt_q[q] != '0) ? 6'd0 : regs_q[q][5:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int q = 0; q < 4; q++) begin
                bbm_cnt_q[q] <= '0;
            end
        end else begin
            for (int q = 0; q < 4; q++) begin
                bbm_cnt_q[q] <= bbm_cnt_d[q];
            end
        end
    end
`else
    always_comb begin
        for (int q = 0; q < 4; q++) begin
            mux_out[q] = regs_q[q][5:0];
        end
    end
`endif

    assign ahb.HREADYOUT = hreadyout_q;
    assign ahb.HRESP     = hresp_q;
    assign ahb.HRDATA    = hrdata_q;
    assign dbg_state     = state_q;

    assign {bus_muxsplit_se_switch_aa_sr, bus_muxsplit_se_switch_bb_sr, bus_muxsplit_se_switch_bb_sl,
            bus_muxsplit_se_switch_bb_s0, bus_muxsplit_se_switch_aa_s0, bus_muxsplit_se_switch_aa_sl} = mux_out[0];
    assign {bus_muxsplit_sw_switch_aa_sr, bus_muxsplit_sw_switch_bb_sr, bus_muxsplit_sw_switch_bb_sl,
            bus_muxsplit_sw_switch_bb_s0, bus_muxsplit_sw_switch_aa_s0, bus_muxsplit_sw_switch_aa_sl} = mux_out[1];
    assign {bus_muxsplit_ne_switch_aa_sr, bus_muxsplit_ne_switch_bb_sr, bus_muxsplit_ne_switch_bb_sl,
            bus_muxsplit_ne_switch_bb_s0, bus_muxsplit_ne_switch_aa_s0, bus_muxsplit_ne_switch_aa_sl} = mux_out[2];
    assign {bus_muxsplit_nw_switch_aa_sr, bus_muxsplit_nw_switch_bb_sr, bus_muxsplit_nw_switch_bb_sl,
            bus_muxsplit_nw_switch_bb_s0, bus_muxsplit_nw_switch_aa_s0, bus_muxsplit_nw_switch_aa_sl} = mux_out[3];

    assign bus_vref_e_ref_sel    = regs_q[4][4:0];
    assign bus_vref_e_vrefgen_en = regs_q[4][8];
    assign bus_vref_w_ref_sel    = regs_q[4][20:16];
    assign bus_vref_w_vrefgen_en = regs_q[4][24];
    assign bus_user_ahb_enable   = regs_q[5][0];
    assign bus_user_irqs_enable  = regs_q[5][31:16];
    assign bus_sio_cfg           = regs_q[6][5:0];

endmodule

// File: tb/tb_regs_system_ahbl.sv
// Randomized AHB-Lite bench for regs_system_ahbl against a word-level register-map model.
// Define MUXSPLIT_BBM_EN (for both bench and design) to exercise the break-before-make path.
`timescale 1ns/1ps
module tb_regs_system_ahbl;

    localparam int BBM  = 4;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic bus_mgmt_select;

    wire [5:0]  se_w, sw_w, ne_w, nw_w;
    wire        e_en_w, w_en_w, ahb_en_w;
    wire [4:0]  e_sel_w, w_sel_w;
    wire [15:0] irqs_w;
    wire [5:0]  sio_w;
    wire [1:0]  dbg_state_w;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model [8];
    logic        status_exp;

    regs_system_ahbl_if #(.ADDR_W(8)) bus ();

    assign bus.HREADY = bus.HREADYOUT;

    regs_system_ahbl #(.ADDR_W(8), .SYNC_STAGES(SYNC), .BBM_CYCLES(BBM)) dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .ahb                          (bus),
        .bus_muxsplit_se_switch_aa_sl (se_w[0]),
        .bus_muxsplit_se_switch_aa_s0 (se_w[1]),
        .bus_muxsplit_se_switch_bb_s0 (se_w[2]),
        .bus_muxsplit_se_switch_bb_sl (se_w[3]),
        .bus_muxsplit_se_switch_bb_sr (se_w[4]),
        .bus_muxsplit_se_switch_aa_sr (se_w[5]),
        .bus_muxsplit_sw_switch_aa_sl (sw_w[0]),
        .bus_muxsplit_sw_switch_aa_s0 (sw_w[1]),
        .bus_muxsplit_sw_switch_bb_s0 (sw_w[2]),
        .bus_muxsplit_sw_switch_bb_sl (sw_w[3]),
        .bus_muxsplit_sw_switch_bb_sr (sw_w[4]),
        .bus_muxsplit_sw_switch_aa_sr (sw_w[5]),
        .bus_muxsplit_ne_switch_aa_sl (ne_w[0]),
        .bus_muxsplit_ne_switch_aa_s0 (ne_w[1]),
        .bus_muxsplit_ne_switch_bb_s0 (ne_w[2]),
        .bus_muxsplit_ne_switch_bb_sl (ne_w[3]),
        .bus_muxsplit_ne_switch_bb_sr (ne_w[4]),
        .bus_muxsplit_ne_switch_aa_sr (ne_w[5]),
        .bus_muxsplit_nw_switch_aa_sl (nw_w[0]),
        .bus_muxsplit_nw_switch_aa_s0 (nw_w[1]),
        .bus_muxsplit_nw_switch_bb_s0 (nw_w[2]),
        .bus_muxsplit_nw_switch_bb_sl (nw_w[3]),
        .bus_muxsplit_nw_switch_bb_sr (nw_w[4]),
        .bus_muxsplit_nw_switch_aa_sr (nw_w[5]),
        .bus_vref_e_vrefgen_en        (e_en_w),
        .bus_vref_w_vrefgen_en        (w_en_w),
        .bus_vref_e_ref_sel           (e_sel_w),
        .bus_vref_w_ref_sel           (w_sel_w),
        .bus_user_ahb_enable          (ahb_en_w),
        .bus_user_irqs_enable         (irqs_w),
        .bus_sio_cfg                  (sio_w),
        .bus_mgmt_select              (bus_mgmt_select),
        .dbg_state                    (dbg_state_w)
    );

    // Clock and reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: register map as plain words
    function automatic logic [31:0] impl_of(input int idx);
        case (idx)
            0, 1, 2, 3: return 32'h0000_003F;
            4:          return 32'h0000_001F | 32'h0000_0100 | 32'h001F_0000 | 32'h0100_0000;
            5:          return 32'hFFFF_0000 | 32'h0000_0001;
            6:          return 32'h0000_003F;
            default:    return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] byte_mask(input logic [2:0] size, input logic [1:0] a);
        case (size)
            3'd0:    return 32'h0000_00FF << (8 * a);
            3'd1:    return 32'h0000_FFFF << (16 * a[1]);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic bit is_bad(input logic [7:0] addr, input logic [2:0] size);
        return (addr >= 8'h20) || (size > 3'd2) || (size == 3'd1 && addr[0]) ||
               (size == 3'd2 && addr[1:0] != 2'b00);
    endfunction

    task automatic model_write(input logic [7:0] addr, input logic [2:0] size, input logic [31:0] wdata);
        int idx;
        logic [31:0] bm;
        idx = int'(addr[4:2]);
        bm  = byte_mask(size, addr[1:0]);
        if (idx != 7) model[idx] = ((model[idx] & ~bm) | (wdata & bm)) & impl_of(idx);
    endtask

    task automatic settle();
`ifdef MUXSPLIT_BBM_EN
        repeat (BBM + 1) begin @(posedge clk); #1; end
`endif
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_mux"}, {8'h0, nw_w, ne_w, sw_w, se_w},
                 {8'h0, model[3][5:0], model[2][5:0], model[1][5:0], model[0][5:0]});
        check_eq({tag, "_vref"}, {7'd0, w_en_w, 3'd0, w_sel_w, 7'd0, e_en_w, 3'd0, e_sel_w}, model[4]);
        check_eq({tag, "_user"}, {irqs_w, 15'd0, ahb_en_w}, model[5]);
        check_eq({tag, "_sio"}, {26'd0, sio_w}, model[6]);
    endtask

    // Driver: one isolated transfer, starting and ending 1ns after a rising edge
    task automatic bus_txn(input bit wr, input logic [7:0] addr, input logic [2:0] size, input logic [31:0] wdata);
        bit bad;
        int idx;
        bad = is_bad(addr, size);
        idx = int'(addr[4:2]);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = addr;
        bus.HWRITE = wr;
        bus.HSIZE  = size;
        @(posedge clk); #1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWDATA = wdata;
        @(negedge clk);
        if (bad) begin
            check_eq("err_c1_hreadyout", bus.HREADYOUT, 1'b0);
            check_eq("err_c1_hresp", bus.HRESP, 1'b1);
            @(posedge clk); @(negedge clk);
            check_eq("err_c2_hreadyout", bus.HREADYOUT, 1'b1);
            check_eq("err_c2_hresp", bus.HRESP, 1'b1);
            check_eq("err_hrdata", bus.HRDATA, 32'h0);
        end else begin
            check_eq("ok_hreadyout", bus.HREADYOUT, 1'b1);
            check_eq("ok_hresp", bus.HRESP, 1'b0);
            if (!wr) check_eq("rd_data", bus.HRDATA, (idx == 7) ? {31'd0, status_exp} : model[idx]);
            else model_write(addr, size, wdata);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0]  ra;
        logic [2:0]  rs;
        logic [31:0] rw;
        bit          rwr;

        for (int i = 0; i < 8; i++) model[i] = 32'h0;
        status_exp      = 1'b0;
        bus_mgmt_select = 1'b0;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HADDR  = 8'h0;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'd0;
        bus.HWDATA = 32'h0;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_hreadyout", bus.HREADYOUT, 1'b1);
        check_eq("rst_hresp", bus.HRESP, 1'b0);
        check_eq("rst_hrdata", bus.HRDATA, 32'h0);
        check_outputs("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) bus_txn(1'b0, 8'(i * 4), 3'd2, 32'h0);

        // SE word write and readback
        bus_txn(1'b1, 8'h00, 3'd2, 32'h0000_002A);
        settle();
        check_eq("se_word", {26'd0, se_w}, 32'h2A);
        bus_txn(1'b0, 8'h00, 3'd2, 32'h0);

        // USER word then pipelined byte write + read of the same word
        bus_txn(1'b1, 8'h14, 3'd2, 32'h0000_0001);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = 8'h17;
        bus.HWRITE = 1'b1;
        bus.HSIZE  = 3'd0;
        @(posedge clk); #1;
        bus.HWDATA = 32'hA5A5_A5A5;
        bus.HADDR  = 8'h14;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'd2;
        model_write(8'h17, 3'd0, 32'hA5A5_A5A5);
        @(posedge clk); #1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        @(negedge clk);
        check_eq("bypass_rd", bus.HRDATA, 32'hA500_0001);
        check_eq("bypass_resp", bus.HRESP, 1'b0);
        @(posedge clk); #1;
        check_eq("user_irqs", {16'd0, irqs_w}, 32'hA500);
        check_eq("user_ahb_en", {31'd0, ahb_en_w}, 32'h1);

        // ERROR cases leave registers untouched
        bus_txn(1'b1, 8'h40, 3'd2, 32'hFFFF_FFFF);
        bus_txn(1'b0, 8'h02, 3'd2, 32'h0);
        bus_txn(1'b0, 8'h00, 3'd3, 32'h0);
        bus_txn(1'b1, 8'h01, 3'd1, 32'hFFFF_FFFF);
        bus_txn(1'b1, 8'h1C, 3'd2, 32'hFFFF_FFFF);
        settle();
        check_outputs("after_err");
        bus_txn(1'b0, 8'h00, 3'd2, 32'h0);
        bus_txn(1'b0, 8'h1C, 3'd2, 32'h0);

        // Status synchroniser latency
        @(negedge clk);
        bus_mgmt_select = 1'b1;
        @(posedge clk); #1;
        bus_txn(1'b0, 8'h1C, 3'd2, 32'h0);
        repeat (SYNC) begin @(posedge clk); #1; end
        status_exp = 1'b1;
        bus_txn(1'b0, 8'h1C, 3'd2, 32'h0);
        bus_mgmt_select = 1'b0;
        repeat (SYNC + 1) begin @(posedge clk); #1; end
        status_exp = 1'b0;
        bus_txn(1'b0, 8'h1C, 3'd2, 32'h0);

`ifdef MUXSPLIT_BBM_EN
        bus_txn(1'b1, 8'h0C, 3'd2, 32'h3F);
        for (int c = 0; c < BBM; c++) begin @(negedge clk); check_eq("bbm_break1", {26'd0, nw_w}, 32'h0); end
        @(negedge clk);
        check_eq("bbm_new1", {26'd0, nw_w}, 32'h3F);
        @(posedge clk); #1;
        bus_txn(1'b1, 8'h0C, 3'd2, 32'h2A);
        bus_txn(1'b1, 8'h0C, 3'd2, 32'h01);
        for (int c = 0; c < BBM; c++) begin @(negedge clk); check_eq("bbm_break2", {26'd0, nw_w}, 32'h0); end
        @(negedge clk);
        check_eq("bbm_new2", {26'd0, nw_w}, 32'h01);
        @(posedge clk); #1;
        bus_txn(1'b1, 8'h0C, 3'd2, 32'h15);
        bus_txn(1'b0, 8'h0C, 3'd2, 32'h0);
        @(negedge clk);
        check_eq("bbm_forced_during_rd", {26'd0, nw_w}, 32'h0);
        @(posedge clk); #1;
        settle();
        bus_txn(1'b1, 8'h0C, 3'd2, 32'h15);
        @(negedge clk);
        check_eq("bbm_nochange", {26'd0, nw_w}, 32'h15);
        @(posedge clk); #1;
`endif

        // Reset in the middle of a write data phase
        bus_txn(1'b1, 8'h18, 3'd2, 32'h15);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = 8'h18;
        bus.HWRITE = 1'b1;
        bus.HSIZE  = 3'd2;
        @(posedge clk); #1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWDATA = 32'h3F;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
        #1;
        check_outputs("rst_mid");
        check_eq("rst_mid_hreadyout", bus.HREADYOUT, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_outputs("post_rst");
        bus_txn(1'b0, 8'h18, 3'd2, 32'h0);

        // Randomized transfers against the model
        for (int n = 0; n < 250; n++) begin
            rwr = 1'($urandom_range(0, 1));
            rs  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            ra  = 8'($urandom_range(0, 39));
            if ($urandom_range(0, 3) != 0) begin
                if (rs == 3'd2) ra = ra & 8'hFC;
                else if (rs == 3'd1) ra = ra & 8'hFE;
            end
            rw = $urandom();
            bus_txn(rwr, ra, rs, rw);
            settle();
            if (n % 5 == 0) check_outputs("rand");
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        check_outputs("final");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regs_system_ahbl.md
Name: regs_system_ahbl

Overview:
- AHB-Lite subordinate holding the system configuration registers.
- Drives every bus_* control field consumed by the system register pass-through stage: muxsplit switches, vref, user AHB/IRQ enables and sio_cfg.
- Returns the bus_mgmt_select status to the bus.
- Sits on the management AHB-Lite fabric, one slot per HSEL.

Parameters:
- ADDR_W, 8, width of HADDR used for decode (byte address; offsets ≥ 0x20 are unmapped).
- SYNC_STAGES, 2, flops in the bus_mgmt_select synchroniser (minimum 2).
- BBM_CYCLES, 4, muxsplit break interval in clk cycles (used only with MUXSPLIT_BBM_EN; minimum 1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- HSEL  in  1  subordinate select
- HADDR  in  ADDR_W  byte address
- HTRANS  in  2  transfer type; NONSEQ/SEQ are active
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 = byte, 1 = half, 2 = word
- HWDATA  in  32  write data (data phase)
- HREADY  in  1  bus ready
- HREADYOUT  out  1  subordinate ready
- HRESP  out  1  1 = ERROR
- HRDATA  out  32  read data
- bus_muxsplit_{se,sw,ne,nw}_switch_{aa_sl,aa_s0,bb_s0,bb_sl,bb_sr,aa_sr}  out  1 each (24 total)  switch controls
- bus_vref_e_vrefgen_en, bus_vref_w_vrefgen_en  out  1  vref enables
- bus_vref_e_ref_sel, bus_vref_w_ref_sel  out  5  vref selects
- bus_user_ahb_enable  out  1
- bus_user_irqs_enable  out  16
- bus_sio_cfg  out  6
- bus_mgmt_select  in  1  asynchronous status

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all registers and bus_* outputs = 0; HREADYOUT = 1; HRESP = 0; HRDATA = 0; synchroniser flops = 0.
- Register map (word offsets):
  - 0x00 SE, 0x04 SW, 0x08 NE, 0x0C NW: bits[5:0] = {aa_sr, bb_sr, bb_sl, bb_s0, aa_s0, aa_sl}, LSB = aa_sl.
  - 0x10 VREF: [4:0] e_ref_sel, [8] e_vrefgen_en, [20:16] w_ref_sel, [24] w_vrefgen_en.
  - 0x14 USER: [0] user_ahb_enable, [31:16] user_irqs_enable.
  - 0x18 SIO: [5:0] sio_cfg.
  - 0x1C STATUS (RO): [0] synchronised bus_mgmt_select. Writes are ignored with OKAY.
  - Unimplemented bits read 0 and ignore writes.
- Address phase is accepted when HSEL & HREADY & HTRANS[1]. Latch offset, HWRITE, HSIZE and the byte-lane mask.
  - Lane mask: byte = 1 lane at HADDR[1:0]; half = lanes {1:0} or {3:2} per HADDR[1]; word = all four lanes.
- Writes are committed at the end of the data phase (clock edge where HREADYOUT = 1) using HWDATA under the lane mask. Outputs update on that edge.
- Reads: HRDATA is registered at the end of the address phase and valid throughout the data phase. Zero wait states.
  - Read-after-write bypass: if a read's address phase coincides with a write data phase to the same offset, HRDATA returns the merged new value.
- ERROR response on any of:
  - offset ≥ 0x20;
  - HSIZE > 2;
  - misalignment (half with HADDR[0] = 1; word with HADDR[1:0] ≠ 0).
- ERROR sequence: cycle 1 HREADYOUT = 0, HRESP = 1; cycle 2 HREADYOUT = 1, HRESP = 1. No register changes; HRDATA = 0.
  - An address phase presented during cycle 1 is not sampled (HREADY = 0).
- IDLE/BUSY or HSEL = 0: no action, OKAY.
- bus_mgmt_select passes through a SYNC_STAGES flop chain. STATUS reflects the value SYNC_STAGES cycles late.
- Reset mid-transfer: everything returns to reset values immediately; the pending write is lost.

Optional Feature:
MUXSPLIT_BBM_EN
- Enabled: a committed write that changes any bit of a muxsplit register starts a per-quadrant break. That quadrant's six outputs are forced to 0 for BBM_CYCLES cycles, then take the new value.
  - A further write to the same quadrant during a break restarts the count and uses the newest value.
  - Readback always returns the register value, not the forced output.
  - Writes with no bit change start no break.
  - The bus is never stalled.
- Disabled: outputs follow the registers on the commit edge. No counters are instantiated.

Test Plan:
- Reset, then read all 8 offsets → HRDATA = 0 everywhere; all bus_* = 0; STATUS = 0 with bus_mgmt_select = 0.
- Word write 0x0000_002A to 0x00 → SE outputs {aa_sr..aa_sl} = 101010 on the commit edge; readback = 0x2A.
- Byte write 0xA5 to 0x17 after word write 0x0000_0001 to 0x14 → user_irqs_enable = 0xA500, user_ahb_enable = 1. Back-to-back read of 0x14 returns 0xA500_0001 (bypass).
- Write 0x40, word read with HADDR = 0x02, and HSIZE = 3 → each gives a two-cycle ERROR (HREADYOUT 0 then 1, HRESP = 1); registers are unchanged.
- Toggle bus_mgmt_select to 1 → STATUS reads 0 up to SYNC_STAGES − 1 cycles after the edge, 1 thereafter.
- With MUXSPLIT_BBM_EN, write 0x3F then 0x01 to 0x0C → NW outputs are 0 for 4 cycles and then 0x3F. The second write mid-break restarts the count, giving 4 zero cycles and then 0x01.
